axi4_to_mi: RTL



---
 rtl/axi4_to_mi.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_to_mi.sv
`default_nettype none
// ============================================================================
// Module      : axi4_to_mi
// Description : AXI4 slave to MI master bridge, one MI request per AXI beat.
//               Optional read timeout when AXI4_TO_MI_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_to_mi #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [ID_WIDTH-1:0]     AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [7:0]              AXI_AWLEN,
  input  logic [1:0]              AXI_AWBURST,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WLAST,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [ID_WIDTH-1:0]     AXI_BID,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [7:0]              AXI_ARLEN,
  input  logic [1:0]              AXI_ARBURST,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     AXI_RID,
  output logic [DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RLAST,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  output logic [ADDR_WIDTH-1:0]   MI_ADDR,
  output logic [DATA_WIDTH-1:0]   MI_DWR,
  output logic [DATA_WIDTH/8-1:0] MI_BE,
  output logic                    MI_WR,
  output logic                    MI_RD,
  input  logic                    MI_ARDY,
  input  logic [DATA_WIDTH-1:0]   MI_DRD,
  input  logic                    MI_DRDY
);

  localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, W_WAIT, W_MI, B_RESP, R_MI, R_WAIT, R_DATA} state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;          // 0: write wins the next AW/AR conflict
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    fixed_q, fixed_d;
  logic                    err_q, err_d;
  logic                    awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                    mi_wr_q, mi_wr_d, mi_rd_q, mi_rd_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, dwr_q, dwr_d;
  logic [STRB_WIDTH-1:0]   be_q, be_d;
  logic [ADDR_WIDTH-1:0]   next_addr;

`ifdef AXI4_TO_MI_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  assign next_addr = fixed_q ? addr_q : addr_q + ADDR_STEP;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    fixed_d   = fixed_q;
    err_d     = err_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    mi_wr_d   = mi_wr_q;
    mi_rd_d   = mi_rd_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    dwr_d     = dwr_q;
    be_d      = be_q;
`ifdef AXI4_TO_MI_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (awready_q && AXI_AWVALID) begin
          id_d     = AXI_AWID;
          addr_d   = AXI_AWADDR;
          cnt_d    = AXI_AWLEN;
          fixed_d  = (AXI_AWBURST == 2'b00);
          err_d    = 1'b0;
          wready_d = 1'b1;
          state_d  = W_WAIT;
        end else if (arready_q && AXI_ARVALID) begin
          id_d    = AXI_ARID;
          addr_d  = AXI_ARADDR;
          cnt_d   = AXI_ARLEN;
          fixed_d = (AXI_ARBURST == 2'b00);
          be_d    = '1;
          mi_rd_d = 1'b1;
          state_d = R_MI;
        end else if (AXI_AWVALID && AXI_ARVALID) begin
          awready_d = ~rr_q;
          arready_d = rr_q;
          rr_d      = ~rr_q;
        end else begin
          awready_d = AXI_AWVALID;
          arready_d = AXI_ARVALID;
        end
      end
      W_WAIT: begin
        if (wready_q && AXI_WVALID) begin
          wready_d = 1'b0;
          dwr_d    = AXI_WDATA;
          be_d     = AXI_WSTRB;
          mi_wr_d  = 1'b1;
          // Misplaced WLAST only taints the response; the counter still rules the burst length
          if (AXI_WLAST != (cnt_q == 8'd0)) err_d = 1'b1;
          state_d  = W_MI;
        end
      end
      W_MI: begin
        if (MI_ARDY) begin
          mi_wr_d = 1'b0;
          if (cnt_q == 8'd0) begin
            bvalid_d = 1'b1;
            bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            state_d  = B_RESP;
          end else begin
            cnt_d    = cnt_q - 8'd1;
            addr_d   = next_addr;
            wready_d = 1'b1;
            state_d  = W_WAIT;
          end
        end
      end
      B_RESP: begin
        if (AXI_BREADY) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      R_MI: begin
        if (MI_ARDY) begin
          mi_rd_d = 1'b0;
`ifdef AXI4_TO_MI_TIMEOUT_EN
          tmo_d   = '0;
`endif
          if (MI_DRDY) begin
            rdata_d  = MI_DRD;
            rresp_d  = RESP_OKAY;
            rvalid_d = 1'b1;
            rlast_d  = (cnt_q == 8'd0);
            state_d  = R_DATA;
          end else begin
            state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (MI_DRDY) begin
          rdata_d  = MI_DRD;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 8'd0);
          state_d  = R_DATA;
        end
`ifdef AXI4_TO_MI_TIMEOUT_EN
        else if (tmo_hit) begin
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 8'd0);
          state_d  = R_DATA;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = next_addr;
            mi_rd_d = 1'b1;
            state_d = R_MI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      mi_wr_q   <= 1'b0;
      mi_rd_q   <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      dwr_q     <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      mi_wr_q   <= mi_wr_d;
      mi_rd_q   <= mi_rd_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      dwr_q     <= dwr_d;
      be_q      <= be_d;
    end
  end

`ifdef AXI4_TO_MI_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  assign AXI_AWREADY = awready_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BID     = id_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_RID     = id_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
  assign AXI_RLAST   = rlast_q;
  assign AXI_RVALID  = rvalid_q;
  assign MI_ADDR     = addr_q;
  assign MI_DWR      = dwr_q;
  assign MI_BE       = be_q;
  assign MI_WR       = mi_wr_q;
  assign MI_RD       = mi_rd_q;

endmodule
`default_nettype wire
